trb_mem_arbiter: RTL and testbench

Time-division arbiter for the single-port trace buffer RAM shared by the Logger and the host read-out path. It runs a fixed three-slot schedule: write, logger read, host read. It generates the Logger's `RW_TURN`, `WRITE_ALLOW` and `READ_ALLOW` strobes from the Logger's ring pointers and drives the RAM command port. It sits in the `CLK_I` domain between Logger and the trace buffer memory, replacing ad-hoc turn generation.

---
 rtl/trb_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_trb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/trb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// trb_mem_arbiter : write / logger-read / host-read time-slot arbiter for the
//                   single-port trace buffer RAM.            Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trb_mem_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  CLEAR_I,
  output logic                  RW_TURN_O,
  output logic                  WRITE_ALLOW_O,
  output logic                  READ_ALLOW_O,
  output logic                  OVERFLOW_O,
  input  logic                  LOG_WRITE_I,
  input  logic [ADDR_WIDTH-1:0] LOG_WPTR_I,
  input  logic [DATA_WIDTH-1:0] LOG_WDATA_I,
  input  logic                  LOG_READ_I,
  input  logic [ADDR_WIDTH-1:0] LOG_RPTR_I,
  output logic [DATA_WIDTH-1:0] LOG_RDATA_O,
  output logic                  LOG_RVALID_O,
  input  logic                  HOST_REQ_I,
  input  logic [ADDR_WIDTH-1:0] HOST_ADDR_I,
  output logic                  HOST_GNT_O,
  output logic [DATA_WIDTH-1:0] HOST_RDATA_O,
  output logic                  HOST_RVALID_O,
  output logic                  MEM_EN_O,
  output logic                  MEM_WE_O,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR_O,
  output logic [DATA_WIDTH-1:0] MEM_WDATA_O,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA_I
);

  typedef enum logic [1:0] {S_WR = 2'd0, S_RD = 2'd1, S_HOST = 2'd2} slot_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_LOG = 2'd1, TAG_HOST = 2'd2} tag_t;

  slot_t                 state, state_next;
  tag_t                  tag_cmd, tag_q;
  logic [ADDR_WIDTH-1:0] fill;
  logic                  write_allow, read_allow, overflow, overflow_set;
  logic                  log_rvalid, host_rvalid;
  logic [DATA_WIDTH-1:0] log_rdata, host_rdata;

  // Modulo occupancy; all-ones means DEPTH-1, the full mark (one slot kept empty).
  assign fill = LOG_WPTR_I - LOG_RPTR_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= S_WR;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = S_WR;
    MEM_EN_O     = 1'b0;
    MEM_WE_O     = 1'b0;
    MEM_ADDR_O   = '0;
    MEM_WDATA_O  = '0;
    HOST_GNT_O   = 1'b0;
    tag_cmd      = TAG_NONE;
    overflow_set = 1'b0;
    if (!CLEAR_I) begin
      case (state)
        S_WR: begin
          state_next = S_RD;
          if (LOG_WRITE_I) begin
            if (write_allow) begin
              MEM_EN_O    = 1'b1;
              MEM_WE_O    = 1'b1;
              MEM_ADDR_O  = LOG_WPTR_I;
              MEM_WDATA_O = LOG_WDATA_I;
            end else begin
              overflow_set = 1'b1;
            end
          end
        end
        S_RD: begin
          state_next = S_HOST;
          if (LOG_READ_I && read_allow) begin
            MEM_EN_O   = 1'b1;
            MEM_ADDR_O = LOG_RPTR_I;
            tag_cmd    = TAG_LOG;
          end
        end
        S_HOST: begin
          state_next = S_WR;
          if (HOST_REQ_I) begin
            MEM_EN_O   = 1'b1;
            MEM_ADDR_O = HOST_ADDR_I;
            HOST_GNT_O = 1'b1;
            tag_cmd    = TAG_HOST;
          end
        end
        default: state_next = S_WR;
      endcase
    end
  end

  // Tag follows the command one cycle; RAM data is captured as the tag retires.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      write_allow <= 1'b1;
      read_allow  <= 1'b0;
      overflow    <= 1'b0;
      tag_q       <= TAG_NONE;
      log_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      log_rdata   <= '0;
      host_rdata  <= '0;
    end else if (CLEAR_I) begin
      write_allow <= 1'b1;
      read_allow  <= 1'b0;
      overflow    <= 1'b0;
      tag_q       <= TAG_NONE;
      log_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      write_allow <= (fill != '1);
      read_allow  <= (fill != '0);
      if (overflow_set) overflow <= 1'b1;
      tag_q       <= tag_cmd;
      log_rvalid  <= (tag_q == TAG_LOG);
      host_rvalid <= (tag_q == TAG_HOST);
      if (tag_q == TAG_LOG)  log_rdata  <= MEM_RDATA_I;
      if (tag_q == TAG_HOST) host_rdata <= MEM_RDATA_I;
    end
  end

  assign RW_TURN_O     = (state == S_WR);
  assign WRITE_ALLOW_O = write_allow;
  assign READ_ALLOW_O  = read_allow;
  assign OVERFLOW_O    = overflow;
  assign LOG_RDATA_O   = log_rdata;
  assign LOG_RVALID_O  = log_rvalid;
  assign HOST_RDATA_O  = host_rdata;
  assign HOST_RVALID_O = host_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_trb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_trb_mem_arbiter : directed bench for trb_mem_arbiter with a RAM model.
//                      Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trb_mem_arbiter;

  logic        clk, rst, clear;
  logic        rw_turn, write_allow, read_allow, overflow;
  logic        log_write, log_read, host_req, host_gnt;
  logic [4:0]  log_wptr, log_rptr, host_addr, mem_addr;
  logic [31:0] log_wdata, log_rdata, host_rdata, mem_wdata, mem_rdata;
  logic        log_rvalid, host_rvalid, mem_en, mem_we;

  logic [31:0] ram [0:31];
  int          vectors = 0;
  int          miscompares = 0;
  int          slot = 0;

  trb_mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .CLK_I(clk), .RST_I(rst), .CLEAR_I(clear),
    .RW_TURN_O(rw_turn), .WRITE_ALLOW_O(write_allow), .READ_ALLOW_O(read_allow),
    .OVERFLOW_O(overflow),
    .LOG_WRITE_I(log_write), .LOG_WPTR_I(log_wptr), .LOG_WDATA_I(log_wdata),
    .LOG_READ_I(log_read), .LOG_RPTR_I(log_rptr),
    .LOG_RDATA_O(log_rdata), .LOG_RVALID_O(log_rvalid),
    .HOST_REQ_I(host_req), .HOST_ADDR_I(host_addr), .HOST_GNT_O(host_gnt),
    .HOST_RDATA_O(host_rdata), .HOST_RVALID_O(host_rvalid),
    .MEM_EN_O(mem_en), .MEM_WE_O(mem_we), .MEM_ADDR_O(mem_addr),
    .MEM_WDATA_O(mem_wdata), .MEM_RDATA_I(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Advance to just after the next rising edge; slot tracks the expected schedule.
  task automatic next_cycle;
    bit restart;
    restart = rst || clear;
    @(posedge clk);
    #1;
    slot = restart ? 0 : (slot + 1) % 3;
  endtask

  task automatic goto_slot(input int s);
    for (int n = 0; n < 3 && slot != s; n++) next_cycle();
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if ({rw_turn, write_allow, read_allow, overflow} !== 4'b1100) begin miscompares++; $display("FAIL reset_flags: got %b want 1100", {rw_turn, write_allow, read_allow, overflow}); end
    vectors++; if ({log_rvalid, host_rvalid, mem_en, mem_we, host_gnt} !== 5'b0) begin miscompares++; $display("FAIL reset_strobes: got %b want 00000", {log_rvalid, host_rvalid, mem_en, mem_we, host_gnt}); end
    vectors++; if ({log_rdata, host_rdata, mem_wdata, mem_addr} !== 101'b0) begin miscompares++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", log_rdata, host_rdata, mem_wdata, mem_addr); end
    @(posedge clk); #1;
    rst  = 1'b0;
    slot = 0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vectors++; if ({rw_turn, write_allow, read_allow, mem_en} !== {(i % 3 == 0), 3'b100}) begin miscompares++; $display("FAIL idle c%0d: got turn/wa/ra/en %b want %b", i, {rw_turn, write_allow, read_allow, mem_en}, {(i % 3 == 0), 3'b100}); end
      next_cycle();
    end
  endtask

  task automatic test_fill;
    log_rptr = 5'd0;
    for (int i = 0; i < 31; i++) begin
      goto_slot(0);
      log_wptr  = 5'(i);
      log_write = 1'b1;
      log_wdata = 32'hA0 + 32'(i);
      @(negedge clk);
      vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'(i), 32'hA0 + 32'(i)}) begin miscompares++; $display("FAIL fill_write %0d: got en/we/addr/data %b%b/%0d/%h want 11/%0d/%h", i, mem_en, mem_we, mem_addr, mem_wdata, i, 32'hA0 + 32'(i)); end
      next_cycle();
      log_write = 1'b0;
      log_wptr  = 5'(i + 1);
      log_wdata = 32'h0;
    end
    next_cycle();
    @(negedge clk);
    vectors++; if ({write_allow, read_allow} !== 2'b01) begin miscompares++; $display("FAIL full_flags: got wa/ra %b want 01", {write_allow, read_allow}); end
    goto_slot(0);
    log_write = 1'b1;
    log_wdata = 32'hBF;
    @(negedge clk);
    vectors++; if ({mem_en, overflow} !== 2'b00) begin miscompares++; $display("FAIL full_write_blocked: got en/ovf %b want 00", {mem_en, overflow}); end
    next_cycle();
    log_write = 1'b0;
    @(negedge clk);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set: got %b want 1", overflow); end
    next_cycle();
  endtask

  task automatic test_log_read;
    goto_slot(0);
    log_rptr = 5'd3;
    next_cycle();
    log_read = 1'b1;
    @(negedge clk);
    vectors++; if ({mem_en, mem_we, mem_addr, read_allow} !== {2'b10, 5'd3, 1'b1}) begin miscompares++; $display("FAIL log_read_cmd: got en/we/addr/ra %b%b/%0d/%b want 10/3/1", mem_en, mem_we, mem_addr, read_allow); end
    next_cycle();
    log_read = 1'b0;
    @(negedge clk);
    vectors++; if (log_rvalid !== 1'b0) begin miscompares++; $display("FAIL log_rvalid_early: got %b want 0", log_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if ({log_rvalid, log_rdata} !== {1'b1, 32'hA3}) begin miscompares++; $display("FAIL log_read_data: got v=%b d=%h want v=1 d=a3", log_rvalid, log_rdata); end
    next_cycle();
    @(negedge clk);
    vectors++; if ({log_rvalid, log_rdata} !== {1'b0, 32'hA3}) begin miscompares++; $display("FAIL log_read_hold: got v=%b d=%h want v=0 d=a3", log_rvalid, log_rdata); end
    next_cycle();
  endtask

  task automatic test_host;
    goto_slot(0);
    host_req  = 1'b1;
    host_addr = 5'd7;
    log_write = 1'b1;
    log_wptr  = 5'd31;
    log_wdata = 32'hCC;
    @(negedge clk);
    vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata, host_gnt} !== {2'b11, 5'd31, 32'hCC, 1'b0}) begin miscompares++; $display("FAIL host_wr_slot: got en/we/addr/data/gnt %b%b/%0d/%h/%b want 11/31/cc/0", mem_en, mem_we, mem_addr, mem_wdata, host_gnt); end
    next_cycle();
    log_write = 1'b0;
    log_wptr  = 5'd0;
    @(negedge clk);
    vectors++; if ({host_gnt, mem_en} !== 2'b00) begin miscompares++; $display("FAIL host_rd_slot: got gnt/en %b want 00", {host_gnt, mem_en}); end
    next_cycle();
    @(negedge clk);
    vectors++; if ({host_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 5'd7}) begin miscompares++; $display("FAIL host_grant: got gnt/en/we/addr %b%b%b/%0d want 110/7", host_gnt, mem_en, mem_we, mem_addr); end
    next_cycle();
    host_req = 1'b0;
    @(negedge clk);
    vectors++; if (host_rvalid !== 1'b0) begin miscompares++; $display("FAIL host_rvalid_early: got %b want 0", host_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if ({host_rvalid, host_rdata, log_rvalid} !== {1'b1, 32'hA7, 1'b0}) begin miscompares++; $display("FAIL host_read_data: got v=%b d=%h lv=%b want v=1 d=a7 lv=0", host_rvalid, host_rdata, log_rvalid); end
    next_cycle();
  endtask

  task automatic test_wrap;
    log_wptr = 5'd0;
    log_rptr = 5'd1;
    next_cycle();
    @(negedge clk);
    vectors++; if ({write_allow, read_allow} !== 2'b01) begin miscompares++; $display("FAIL wrap_full: got wa/ra %b want 01", {write_allow, read_allow}); end
    next_cycle();
    log_wptr = 5'd17;
    log_rptr = 5'd17;
    next_cycle();
    @(negedge clk);
    vectors++; if ({write_allow, read_allow} !== 2'b10) begin miscompares++; $display("FAIL wrap_empty: got wa/ra %b want 10", {write_allow, read_allow}); end
    next_cycle();
  endtask

  task automatic test_clear;
    log_wptr = 5'd10;
    log_rptr = 5'd3;
    next_cycle();
    goto_slot(1);
    log_read = 1'b1;
    @(negedge clk);
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 5'd3}) begin miscompares++; $display("FAIL clear_pre_read: got en/addr %b/%0d want 1/3", mem_en, mem_addr); end
    next_cycle();
    log_read  = 1'b0;
    clear     = 1'b1;
    host_req  = 1'b1;
    host_addr = 5'd5;
    @(negedge clk);
    vectors++; if ({mem_en, host_gnt} !== 2'b00) begin miscompares++; $display("FAIL clear_no_cmd: got en/gnt %b want 00", {mem_en, host_gnt}); end
    next_cycle();
    clear    = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    vectors++; if ({rw_turn, overflow, write_allow, read_allow, log_rvalid} !== 5'b10100) begin miscompares++; $display("FAIL clear_after: got turn/ovf/wa/ra/lv %b want 10100", {rw_turn, overflow, write_allow, read_allow, log_rvalid}); end
    next_cycle();
    @(negedge clk);
    vectors++; if ({rw_turn, read_allow, log_rvalid, log_rdata} !== {3'b010, 32'hA3}) begin miscompares++; $display("FAIL clear_recover: got turn/ra/lv %b d=%h want 010 d=a3", {rw_turn, read_allow, log_rvalid}, log_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_midread;
    goto_slot(1);
    log_read = 1'b1;
    @(negedge clk);
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL midreset_cmd: got en %b want 1", mem_en); end
    next_cycle();
    log_read = 1'b0;
    rst      = 1'b1;
    slot     = 0;
    @(negedge clk);
    vectors++; if ({rw_turn, log_rvalid, log_rdata, host_rdata} !== {2'b10, 64'h0}) begin miscompares++; $display("FAIL midreset_state: got turn/lv %b d=%h hd=%h want 10 d=0 hd=0", {rw_turn, log_rvalid}, log_rdata, host_rdata); end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({log_rvalid, host_rvalid} !== 2'b00) begin miscompares++; $display("FAIL midreset_no_valid c%0d: got %b want 00", i, {log_rvalid, host_rvalid}); end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    clk = 1'b0; rst = 1'b1; clear = 1'b0;
    log_write = 1'b0; log_wptr = 5'd0; log_wdata = 32'h0;
    log_read = 1'b0; log_rptr = 5'd0;
    host_req = 1'b0; host_addr = 5'd0;
    test_reset();
    test_idle();
    test_fill();
    test_log_read();
    test_host();
    test_wrap();
    test_clear();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
